// File: rtl/bandeja_rolhas.sv
// Stopper tray controller: tracks the stopper count, serves capping requests
// and drives a registered refill request with a timeout alarm.
module bandeja_rolhas #(
  parameter int unsigned CAPACIDADE = 25,
  parameter int unsigned LIMIAR     = 5,
  parameter int unsigned LOTE       = 20,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vedar,
  input  logic       reabastecer,
  output logic       ativar,
  output logic       vedar_ok,
  output logic [4:0] rolhas,
  output logic       vazia,
  output logic       alarme
);

  localparam int unsigned CW = 5;
  localparam int unsigned SW = 6;
  localparam int unsigned TW = 4;

  localparam logic [1:0] OCIOSO       = 2'd0;
  localparam logic [1:0] PEDE         = 2'd1;
  localparam logic [1:0] ESPERA_BAIXO = 2'd2;
  localparam logic [1:0] FALHA        = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nx;
  logic [CW-1:0] rolhas_nx;
  logic          reab_q;
  logic          reab_sub;
  logic          refill;
  logic [SW-1:0] soma;
  logic [SW-1:0] cheio;
  logic          ok_nx;
  logic          ativar_nx;
  logic          alarme_nx;

  // Empty flag decoded straight from the count register.
  assign vazia = (rolhas == '0);

  // Next-state, count, timer and output decode.
  always_comb begin
    state_nx  = state;
    timer_nx  = '0;
    rolhas_nx = rolhas;
    ok_nx     = 1'b0;

    // Rising edge of the refill strobe; only honoured while a request is open.
    reab_sub = reabastecer & ~reab_q;
    refill   = reab_sub & ((state == PEDE) | (state == FALHA));

    // Refill sum at 6 bits so it cannot wrap before saturation.
    soma  = SW'(rolhas) + SW'(LOTE);
    cheio = (soma > SW'(CAPACIDADE)) ? SW'(CAPACIDADE) : soma;

    // Refilled count is always non-zero, so a concurrent request is served.
    if (refill) begin
      rolhas_nx = CW'(cheio) - CW'(vedar);
      ok_nx     = vedar;
    end else if (vedar && (rolhas != '0)) begin
      rolhas_nx = rolhas - CW'(1);
      ok_nx     = 1'b1;
    end

    case (state)
      OCIOSO: begin
        if (rolhas <= CW'(LIMIAR)) state_nx = PEDE;
      end
      PEDE: begin
        if (refill) begin
          state_nx = ESPERA_BAIXO;
        end else begin
          timer_nx = timer + TW'(1);
          if (timer == TW'(TIMEOUT - 1)) state_nx = FALHA;
        end
      end
      FALHA: begin
        if (refill) begin
          state_nx = ESPERA_BAIXO;
        end else begin
          timer_nx = (&timer) ? timer : timer + TW'(1);
        end
      end
      default: begin
        // ESPERA_BAIXO: wait for the strobe to drop before re-arming.
        if (!reabastecer) state_nx = OCIOSO;
      end
    endcase

    // Request and alarm are registered copies of the next state decode.
    ativar_nx = (state_nx == PEDE) | (state_nx == FALHA);
    alarme_nx = (state_nx == FALHA);
  end

  // State and registered outputs; reset fills the tray and drops the request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= OCIOSO;
      timer    <= '0;
      rolhas   <= CW'(CAPACIDADE);
      reab_q   <= 1'b0;
      vedar_ok <= 1'b0;
      ativar   <= 1'b0;
      alarme   <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      rolhas   <= rolhas_nx;
      reab_q   <= reabastecer;
      vedar_ok <= ok_nx;
      ativar   <= ativar_nx;
      alarme   <= alarme_nx;
    end
  end

endmodule

// File: tb/tb_bandeja_rolhas.sv
// Bench for bandeja_rolhas: table-driven vectors and loops feed a scoreboard
// queue; a checker pops and compares one record after every rising edge.
module tb_bandeja_rolhas;

  logic       clk = 1'b0;
  logic       rst;
  logic       vedar;
  logic       reabastecer;
  logic       ativar;
  logic       vedar_ok;
  logic [4:0] rolhas;
  logic       vazia;
  logic       alarme;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v;
    logic       r;
    logic [4:0] er;
    logic       eok;
    logic       ea;
    logic       eal;
  } vec_t;

  typedef struct {
    logic [4:0] er;
    logic       eok;
    logic       ea;
    logic       eal;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];

  bandeja_rolhas dut (
    .clk(clk),
    .rst(rst),
    .vedar(vedar),
    .reabastecer(reabastecer),
    .ativar(ativar),
    .vedar_ok(vedar_ok),
    .rolhas(rolhas),
    .vazia(vazia),
    .alarme(alarme)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the edge.
  task automatic drive(input logic v, input logic r, input int er,
                       input logic eok, input logic ea, input logic eal);
    exp_t e;
    @(negedge clk);
    vedar       = v;
    reabastecer = r;
    e.er  = 5'(er);
    e.eok = eok;
    e.ea  = ea;
    e.eal = eal;
    sb.push_back(e);
  endtask

  task automatic apply_tbl(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      drive(tbl[i].v, tbl[i].r, int'(tbl[i].er), tbl[i].eok, tbl[i].ea, tbl[i].eal);
  endtask

  // Bounded wait until every queued expectation has been checked.
  task automatic drain();
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d records left, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard checker: one record per rising edge, sampled 1 time unit later.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rolhas",   int'(rolhas),   int'(e.er));
      chk("vedar_ok", int'(vedar_ok), int'(e.eok));
      chk("ativar",   int'(ativar),   int'(e.ea));
      chk("alarme",   int'(alarme),   int'(e.eal));
      chk("vazia",    int'(vazia),    (e.er == 5'd0) ? 1 : 0);
    end
  end

  initial begin
    // In PEDE at 5: single-cycle pulse refills to 25, then back to idle.
    tbl[0]  = '{1'b0, 1'b1, 5'd25, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 5'd25, 1'b0, 1'b0, 1'b0};
    // Re-rise in OCIOSO is ignored.
    tbl[2]  = '{1'b0, 1'b1, 5'd25, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 5'd25, 1'b0, 1'b0, 1'b0};
    // At 3: strobe held 4 cycles with vedar -> 22, 21, 20, 19, one refill only.
    tbl[4]  = '{1'b1, 1'b1, 5'd22, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 5'd21, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 5'd20, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 5'd19, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 5'd19, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 5'd19, 1'b0, 1'b0, 1'b0};
    // From FALHA at 0: refill with vedar -> 19, acknowledge, alarm cleared.
    tbl[10] = '{1'b1, 1'b1, 5'd19, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 5'd19, 1'b0, 1'b0, 1'b0};

    rst = 1'b0;
    vedar = 1'b0;
    reabastecer = 1'b0;
    #12;
    chk("reset_rolhas", int'(rolhas), 25);
    chk("reset_ativar", int'(ativar), 0);
    chk("reset_ok",     int'(vedar_ok), 0);
    chk("reset_alarme", int'(alarme), 0);
    chk("reset_vazia",  int'(vazia), 0);
    @(negedge clk);
    rst = 1'b1;

    // 20 consumptions 25 -> 5; request rises one cycle after reaching 5.
    for (int k = 1; k <= 20; k++) drive(1'b1, 1'b0, 25 - k, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b0);
    apply_tbl(0, 3);

    // 22 consumptions 25 -> 3, request open from the 21st edge on.
    for (int k = 1; k <= 22; k++) drive(1'b1, 1'b0, 25 - k, 1'b1, (k >= 21), 1'b0);
    apply_tbl(4, 9);

    // 19 -> 0, vedar on empty dropped, then timeout raises the alarm.
    for (int k = 1; k <= 32; k++)
      drive((k <= 21), 1'b0, (k <= 19) ? 19 - k : 0, (k <= 19), (k >= 15), (k >= 30));
    apply_tbl(10, 11);

    // Open a request, then assert reset between edges.
    for (int k = 1; k <= 15; k++) drive(1'b1, 1'b0, 19 - k, 1'b1, (k >= 15), 1'b0);
    drain();
    vedar = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_async_ativar", int'(ativar), 1);
    rst = 1'b0;
    #1;
    chk("async_ativar", int'(ativar), 0);
    chk("async_rolhas", int'(rolhas), 25);
    chk("async_alarme", int'(alarme), 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 25, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 24, 1'b1, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bandeja_rolhas.md
BANDEJA_ROLHAS -- requirements
Module: bandeja_rolhas

Interface
REQ-001 Parameter CAPACIDADE, default 25, is the maximum number of stoppers the tray holds.
REQ-002 Parameter LIMIAR, default 5, is the count at or below which a refill is requested.
REQ-003 Parameter LOTE, default 20, is the number of stoppers added per refill.
REQ-004 Parameter TIMEOUT, default 15, is the number of cycles of unanswered request before the alarm is raised.
REQ-005 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 vedar  input  1  capping station requests one stopper this cycle.
REQ-008 reabastecer  input  1  refill strobe from the dispenser; level signal, possibly several cycles wide.
REQ-009 ativar  output  1  refill request to the dispenser; SHALL be driven directly from a register, glitch-free, because the dispenser derives a clock from it.
REQ-010 vedar_ok  output  1  one-cycle acknowledge that a stopper was delivered.
REQ-011 rolhas  output  5  current tray count, registered.
REQ-012 vazia  output  1  high when rolhas == 0; combinational decode of the register.
REQ-013 alarme  output  1  dispenser failed to answer within TIMEOUT cycles.

Function
REQ-014 The FSM SHALL have four states: OCIOSO, PEDE, ESPERA_BAIXO and FALHA.
REQ-015 The block SHALL register reabastecer into reab_q; a refill event (reab_sub) SHALL be reabastecer=1 while reab_q=0.
REQ-016 Consumption: when vedar=1, rolhas>0 and there is no refill event, rolhas SHALL decrement by 1 on the next edge, and vedar_ok SHALL be 1 for exactly that following cycle.
REQ-017 When vedar=1 and rolhas=0 with no refill event, rolhas SHALL stay 0, vedar_ok SHALL stay 0, and the request SHALL be dropped, not queued.
REQ-018 OCIOSO: ativar=0; the FSM SHALL go to PEDE when rolhas <= LIMIAR, evaluated on the registered count.
REQ-019 PEDE: ativar=1 and the timer SHALL increment each cycle.
REQ-020 PEDE on reab_sub: rolhas SHALL become min(rolhas+LOTE, CAPACIDADE) minus 1 if vedar=1, the FSM SHALL go to ESPERA_BAIXO, and the timer SHALL clear.
REQ-021 PEDE with timer == TIMEOUT-1 and no reab_sub: the FSM SHALL go to FALHA.
REQ-022 FALHA: ativar=1 and alarme=1; on reab_sub the FSM SHALL apply the refill as in REQ-020, clear alarme, and go to ESPERA_BAIXO.
REQ-023 ESPERA_BAIXO: ativar=0; the FSM SHALL go to OCIOSO when reabastecer=0.
REQ-024 A reabastecer that stays high or re-rises in ESPERA_BAIXO or OCIOSO SHALL be ignored (no count change).
REQ-025 Simultaneous refill and vedar SHALL set vedar_ok=1, since the count after the refill is always > 0.
REQ-026 The refill sum SHALL be computed at 6 bits and saturated to CAPACIDADE; rolhas SHALL never exceed CAPACIDADE and never wrap below 0.
REQ-027 Consumption SHALL continue in every state, including PEDE and FALHA.
REQ-028 The timer SHALL be 4 bits, SHALL be held at 0 outside PEDE, and SHALL saturate in FALHA.

Reset
REQ-029 While rst=0: rolhas=CAPACIDADE (25), state=OCIOSO, ativar=0, vedar_ok=0, alarme=0, reab_q=0, timer=0.
REQ-030 These values SHALL apply immediately, independent of clk.
REQ-031 A reset asserted mid-request SHALL abort the request; ativar SHALL fall asynchronously.
REQ-032 After rst rises, the first active edge SHALL behave as in OCIOSO with a full tray.

Verification
REQ-033 Reset, then vedar held for 20 cycles -> rolhas 25 down to 5, vedar_ok high each cycle, ativar rises the cycle after rolhas=5.
REQ-034 In PEDE with rolhas=5, one-cycle reabastecer pulse -> rolhas=25, state ESPERA_BAIXO, ativar=0 next cycle, then OCIOSO.
REQ-035 rolhas=3, reabastecer held 4 cycles together with vedar -> single refill to min(23,25)-1=22, then decrements to 19 over the following three cycles, with no second refill.
REQ-036 PEDE with reabastecer held 0 -> alarme=1 after 15 cycles, ativar stays 1; later pulse -> alarme=0, rolhas refilled.
REQ-037 rolhas=0 with vedar=1 -> vazia=1, vedar_ok=0, rolhas stays 0; then refill with vedar -> rolhas=19, vedar_ok=1.
REQ-038 rst=0 asserted between clock edges during PEDE -> ativar=0 and rolhas=25 without waiting for clk.
